uart_tx_arbiter: RTL

- Shares one UART driver transmit path between two requesters: req0 carries forwarded (MITM pass-through) traffic, req1 carries injected traffic.
- Arbitrates between them and latches the winning word.
- Sequences the driver's start/ready handshake and enforces a minimum idle gap between frames.
- Sits between the forwarding/injection logic and the UART driver's tx_data / cmd_tx_start / tx_ready pins.

---
 rtl/uart_tx_arbiter.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/uart_tx_arbiter.sv
// Two-requester arbiter in front of a UART driver: latches the winning word, pulses the start
// command, waits out the frame, then enforces an idle gap. Define UART_TX_ARBITER_RR_EN for round-robin ties.
module uart_tx_arbiter #(
  parameter int NUM_DATA_BITS = 8,
  parameter int GAP_CYCLES    = 16,
  parameter int START_TIMEOUT = 8
) (
  input  logic                     sys_clk,
  input  logic                     rst,
  input  logic                     req0_valid,
  input  logic [NUM_DATA_BITS-1:0] req0_data,
  output logic                     req0_ready,
  input  logic                     req1_valid,
  input  logic [NUM_DATA_BITS-1:0] req1_data,
  output logic                     req1_ready,
  input  logic                     drv_tx_ready,
  output logic                     drv_cmd_tx_start,
  output logic [NUM_DATA_BITS-1:0] drv_tx_data,
  output logic                     busy,
  output logic                     grant_id,
  output logic                     err_timeout
);

  localparam int GAP_W    = $clog2((GAP_CYCLES >= 2) ? GAP_CYCLES : 2);
  localparam int TO_W     = $clog2((START_TIMEOUT >= 2) ? START_TIMEOUT : 2);
  localparam int GAP_LOAD = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
  localparam int TO_LAST  = (START_TIMEOUT > 0) ? START_TIMEOUT - 1 : 0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_WAIT_BUSY,
    S_WAIT_DONE,
    S_GAP
  } state_t;

  state_t           state_q, state_d;
  logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
  logic             win0, win1;
  logic             can_grant;
  logic             xfer0, xfer1;

  assign can_grant  = (state_q == S_IDLE) && drv_tx_ready && (gap_cnt_q == '0) && !rst;
  assign req0_ready = can_grant && win0;
  assign req1_ready = can_grant && win1;
  assign xfer0      = req0_valid && req0_ready;
  assign xfer1      = req1_valid && req1_ready;
  assign busy       = (state_q != S_IDLE);

`ifdef UART_TX_ARBITER_RR_EN
  // rr_last_q holds the id granted most recently; a tie goes to the other requester.
  logic rr_last_q;

  assign win0 = req0_valid && (!req1_valid || rr_last_q);
  assign win1 = req1_valid && (!req0_valid || !rr_last_q);

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      rr_last_q <= 1'b1;
    end else if (xfer0) begin
      rr_last_q <= 1'b0;
    end else if (xfer1) begin
      rr_last_q <= 1'b1;
    end
  end
`else
  assign win0 = req0_valid;
  assign win1 = req1_valid && !req0_valid;
`endif

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      to_cnt_q  <= '0;
      gap_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      to_cnt_q  <= to_cnt_d;
      gap_cnt_q <= gap_cnt_d;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      drv_tx_data <= '0;
      grant_id    <= 1'b0;
    end else if (xfer0) begin
      drv_tx_data <= req0_data;
      grant_id    <= 1'b0;
    end else if (xfer1) begin
      drv_tx_data <= req1_data;
      grant_id    <= 1'b1;
    end
  end

  // The WAIT_DONE cycle that sees tx_ready high is the first gap cycle, so the
  // next grant lands exactly GAP_CYCLES cycles after tx_ready rises.
  always_comb begin
    state_d          = state_q;
    to_cnt_d         = to_cnt_q;
    gap_cnt_d        = gap_cnt_q;
    drv_cmd_tx_start = 1'b0;
    err_timeout      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (xfer0 || xfer1) begin
          state_d = S_START;
        end
      end
      S_START: begin
        drv_cmd_tx_start = 1'b1;
        to_cnt_d         = '0;
        state_d          = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        if (!drv_tx_ready) begin
          state_d = S_WAIT_DONE;
        end else if (to_cnt_q == TO_W'(TO_LAST)) begin
          err_timeout = 1'b1;
          state_d     = S_IDLE;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end
      S_WAIT_DONE: begin
        if (drv_tx_ready) begin
          if (GAP_CYCLES <= 1) begin
            state_d = S_IDLE;
          end else begin
            gap_cnt_d = GAP_W'(GAP_LOAD);
            state_d   = S_GAP;
          end
        end
      end
      S_GAP: begin
        if (gap_cnt_q <= GAP_W'(1)) begin
          gap_cnt_d = '0;
          state_d   = S_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q - GAP_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule
